piso_sched: RTL and testbench

- Round-robin scheduler that shares one parallel-in/serial-out shift register between two parallel-word requesters.
- Accepts words through a valid/ready handshake and sequences load, then WIDTH shift cycles, then an optional idle gap.
- Tags every serial bit with frame-last and source markers.
- Sits between two parallel producers and a single-bit serial link.

---
 rtl/piso_sched_pkg.sv | 19 +
 rtl/piso_sched_if.sv | 26 ++
 rtl/piso_shreg.sv | 31 +++
 rtl/piso_sched.sv | 184 ++++++++++++++++++
 tb/tb_piso_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_sched_pkg.sv
// Shared types and helpers for the piso_sched round-robin serializer.
package piso_sched_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Number of parallel requesters sharing the shift register
    localparam int NUM_REQ = 2;

    // Counter width able to hold 0..n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_sched_if.sv
// Requester and serial-link bundle for piso_sched.
// master: the producers / link consumer side; slave: the scheduler.
interface piso_sched_if
    import piso_sched_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     so;
    logic                     so_valid;
    logic                     so_last;
    logic                     so_src;
    logic                     busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, so, so_valid, so_last, so_src, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, so, so_valid, so_last, so_src, busy
    );
endinterface

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, MSB first, zero fill.
// Load wins over shift when both are asserted.
module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pi,
    output logic             msb
);

    logic [WIDTH-1:0] r_data;

    // Shift register storage: clear, load, or shift left
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
        end else if (load) begin
            r_data <= pi;
        end else if (shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end else begin
            r_data <= r_data;
        end
    end

    assign msb = r_data[WIDTH-1];

endmodule

// File: rtl/piso_sched.sv
// Round-robin scheduler feeding two parallel requesters into one serial link.
// Frame = load cycle, then one bit per cycle MSB first, then GAP_CYCLES idle.
// Optional build macro PISO_SCHED_PARITY_EN appends an even-parity bit
// after the LSB and moves so_last onto it.
module piso_sched
    import piso_sched_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input logic         clk,
    input logic         rst,
    piso_sched_if.slave bus
);

`ifdef PISO_SCHED_PARITY_EN
    localparam int FRAME_W = WIDTH + 1;
`else
    localparam int FRAME_W = WIDTH;
`endif
    localparam int CNT_W = cnt_width(FRAME_W);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

`ifdef PISO_SCHED_PARITY_EN
    // Even parity over the accepted word
    function automatic logic f_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_bit_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic               r_src;
    logic               w_src_nxt;
    logic               r_last_grant;
    logic               w_last_grant_nxt;
    logic               r_rst_d;

    logic               w_grant_en;
    logic [1:0]         w_grant;
    logic               w_sel;
    logic               w_xfer;
    logic               w_load;
    logic               w_shift;
    logic [WIDTH-1:0]   w_word;
    logic [FRAME_W-1:0] w_pi;
    logic               w_msb;

    // Grants are withheld during reset and for the cycle right after it
    assign w_grant_en = (r_state == IDLE) && !rst && !r_rst_d;

    // Round-robin grant: a lone requester wins, a tie goes away from last_grant
    always_comb begin
        w_grant = 2'b00;
        w_sel   = 1'b0;
        if (w_grant_en) begin
            case (bus.req_valid)
                2'b01: begin
                    w_grant = 2'b01;
                    w_sel   = 1'b0;
                end
                2'b10: begin
                    w_grant = 2'b10;
                    w_sel   = 1'b1;
                end
                2'b11: begin
                    w_sel   = ~r_last_grant;
                    w_grant = r_last_grant ? 2'b01 : 2'b10;
                end
                default: begin
                    w_grant = 2'b00;
                    w_sel   = 1'b0;
                end
            endcase
        end else begin
            w_grant = 2'b00;
            w_sel   = 1'b0;
        end
    end

    assign w_xfer = |w_grant;
    assign w_word = w_sel ? bus.req_data[WIDTH +: WIDTH] : bus.req_data[0 +: WIDTH];

`ifdef PISO_SCHED_PARITY_EN
    assign w_pi = {w_word, f_parity(w_word)};
`else
    assign w_pi = w_word;
`endif

    // Next-state and datapath control for IDLE -> SHIFT -> GAP sequencing
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_src_nxt        = r_src;
        w_last_grant_nxt = r_last_grant;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_load           = 1'b1;
                    w_bit_cnt_nxt    = CNT_LOAD;
                    w_src_nxt        = w_sel;
                    w_last_grant_nxt = w_sel;
                    w_state_nxt      = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_bit_cnt == {CNT_W{1'b0}}) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_gap_cnt == {GAP_W{1'b0}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and arbitration history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= {CNT_W{1'b0}};
            r_gap_cnt    <= {GAP_W{1'b0}};
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_src        <= w_src_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Remembers that reset was sampled on the previous edge
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
    end

    piso_shreg #(
        .WIDTH (FRAME_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .pi    (w_pi),
        .msb   (w_msb)
    );

    // All serial outputs come from registered state; only req_ready is combinational
    assign bus.req_ready = w_grant;
    assign bus.so        = (r_state == SHIFT) ? w_msb : 1'b0;
    assign bus.so_valid  = (r_state == SHIFT);
    assign bus.so_last   = (r_state == SHIFT) && (r_bit_cnt == {CNT_W{1'b0}});
    assign bus.so_src    = r_src;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_piso_sched.sv
// Self-checking bench for piso_sched (WIDTH=4; GAP_CYCLES=1 and 0 instances).
// Expected serial bits are queued when a word is offered and popped per bit.
module tb_piso_sched;

    localparam int W = 4;
`ifdef PISO_SCHED_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    localparam int PERIOD  = FRAME + 1 + 1;
    localparam int PERIOD0 = FRAME + 1;

    typedef struct packed {
        logic b;
        logic last;
        logic src;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    sb_t  q[$];
    sb_t  e;

    piso_sched_if #(.WIDTH(W)) b  ();
    piso_sched_if #(.WIDTH(W)) b0 ();

    piso_sched #(.WIDTH(W), .GAP_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    piso_sched #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    always #5 clk = ~clk;

    function automatic void push_word(input logic [W-1:0] d, input logic s);
        sb_t x;
        for (int i = W - 1; i >= 0; i--) begin
            x.b    = d[i];
            x.last = (i == 0) && (FRAME == W);
            x.src  = s;
            q.push_back(x);
        end
`ifdef PISO_SCHED_PARITY_EN
        x.b    = ^d;
        x.last = 1'b1;
        x.src  = s;
        q.push_back(x);
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        b.req_valid  = 2'b00;
        b0.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        b.req_valid = 2'b11;
        b.req_data  = {4'b0011, 4'b1100};
        @(negedge clk); #1;
        n_vec++;
        if ({b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected 0000000", {b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_after: got %b expected 0000000", {b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy});
        end
        @(negedge clk); #1;
        n_vec++;
        if (b.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_prio: ready got %b expected 01", b.req_ready);
        end
        b.req_valid = 2'b00;
        @(negedge clk); #1;
    endtask

    task automatic run_single(input string name, input logic [W-1:0] d, input bit scramble);
        @(negedge clk);
        b.req_data  = {4'b0000, d};
        b.req_valid = 2'b01;
        #1;
        n_vec++;
        if ({b.req_ready, b.so_valid, b.busy} !== 4'b0100) begin
            n_err++;
            $display("FAIL %s_accept: got %b expected 0100", name, {b.req_ready, b.so_valid, b.busy});
        end
        push_word(d, 1'b0);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk); #1;
            if (k == 0) begin
                b.req_valid = 2'b00;
                if (scramble) b.req_data = {4'b0000, 4'b0000};
            end
            e = q.pop_front();
            n_vec++;
            if ({b.so_valid, b.so, b.so_last, b.so_src, b.req_ready, b.busy} !== {1'b1, e.b, e.last, e.src, 2'b00, 1'b1}) begin
                n_err++;
                $display("FAIL %s_bit%0d: got %b expected %b", name, k,
                         {b.so_valid, b.so, b.so_last, b.so_src, b.req_ready, b.busy}, {1'b1, e.b, e.last, e.src, 2'b00, 1'b1});
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if ({b.so_valid, b.so, b.so_last, b.busy} !== 4'b0001) begin
            n_err++;
            $display("FAIL %s_gap: got %b expected 0001", name, {b.so_valid, b.so, b.so_last, b.busy});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({b.busy, b.so_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_idle: got %b expected 00", name, {b.busy, b.so_valid});
        end
    endtask

    task automatic test_basic();
        run_single("basic", 4'b1011, 1'b0);
    endtask

    task automatic test_data_change();
        run_single("data_change", 4'b1011, 1'b1);
    endtask

    task automatic test_parity_word();
        run_single("parity_word", 4'b1001, 1'b0);
    endtask

    task automatic test_alternate();
        int  ph;
        logic s;
        do_reset();
        b.req_data  = {4'b0011, 4'b1100};
        b.req_valid = 2'b11;
        #1;
        for (int c = 0; c < 4 * PERIOD; c++) begin
            ph = c % PERIOD;
            s  = ((c / PERIOD) % 2) == 1;
            if (ph == 0) begin
                n_vec++;
                if ({b.req_ready, b.so_valid, b.busy} !== {(s ? 2'b10 : 2'b01), 2'b00}) begin
                    n_err++;
                    $display("FAIL alt_accept c=%0d: got %b expected %b", c, {b.req_ready, b.so_valid, b.busy}, {(s ? 2'b10 : 2'b01), 2'b00});
                end
                push_word(s ? 4'b0011 : 4'b1100, s);
            end else if (ph <= FRAME) begin
                e = q.pop_front();
                n_vec++;
                if ({b.so_valid, b.so, b.so_last, b.so_src, b.req_ready, b.busy} !== {1'b1, e.b, e.last, e.src, 2'b00, 1'b1}) begin
                    n_err++;
                    $display("FAIL alt_bit c=%0d: got %b expected %b", c,
                             {b.so_valid, b.so, b.so_last, b.so_src, b.req_ready, b.busy}, {1'b1, e.b, e.last, e.src, 2'b00, 1'b1});
                end
            end else begin
                n_vec++;
                if ({b.so_valid, b.so, b.req_ready, b.busy} !== 5'b00001) begin
                    n_err++;
                    $display("FAIL alt_gap c=%0d: got %b expected 00001", c, {b.so_valid, b.so, b.req_ready, b.busy});
                end
            end
            if (c == 4 * PERIOD - 1) b.req_valid = 2'b00;
            @(negedge clk); #1;
        end
        n_vec++;
        if ({b.busy, b.req_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL alt_end: got %b expected 000", {b.busy, b.req_ready});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b.req_data  = {4'b0000, 4'b1011};
        b.req_valid = 2'b01;
        #1;
        n_vec++;
        if (b.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rmid_accept: ready got %b expected 01", b.req_ready);
        end
        push_word(4'b1011, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            b.req_valid = 2'b00;
            e = q.pop_front();
            n_vec++;
            if ({b.so_valid, b.so, b.so_last, b.so_src} !== {1'b1, e.b, e.last, e.src}) begin
                n_err++;
                $display("FAIL rmid_bit%0d: got %b expected %b", k, {b.so_valid, b.so, b.so_last, b.so_src}, {1'b1, e.b, e.last, e.src});
            end
        end
        rst = 1'b1;
        q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        b.req_data  = {4'b0110, 4'b0000};
        b.req_valid = 2'b10;
        #1;
        n_vec++;
        if ({b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy} !== 7'd0) begin
            n_err++;
            $display("FAIL rmid_after: got %b expected 0000000", {b.req_ready, b.so_valid, b.so, b.so_last, b.so_src, b.busy});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({b.req_ready, b.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL rmid_req1: got %b expected 100", {b.req_ready, b.busy});
        end
        push_word(4'b0110, 1'b1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk); #1;
            b.req_valid = 2'b00;
            e = q.pop_front();
            n_vec++;
            if ({b.so_valid, b.so, b.so_last, b.so_src} !== {1'b1, e.b, e.last, e.src}) begin
                n_err++;
                $display("FAIL rmid_r1bit%0d: got %b expected %b", k, {b.so_valid, b.so, b.so_last, b.so_src}, {1'b1, e.b, e.last, e.src});
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_gap0();
        int ph;
        do_reset();
        b0.req_data  = {4'b1001, 4'b0000};
        b0.req_valid = 2'b10;
        #1;
        for (int c = 0; c < 3 * PERIOD0; c++) begin
            ph = c % PERIOD0;
            if (ph == 0) begin
                n_vec++;
                if ({b0.req_ready, b0.so_valid, b0.busy} !== 4'b1000) begin
                    n_err++;
                    $display("FAIL gap0_accept c=%0d: got %b expected 1000", c, {b0.req_ready, b0.so_valid, b0.busy});
                end
                push_word(4'b1001, 1'b1);
            end else begin
                e = q.pop_front();
                n_vec++;
                if ({b0.so_valid, b0.so, b0.so_last, b0.so_src, b0.req_ready, b0.busy} !== {1'b1, e.b, e.last, e.src, 2'b00, 1'b1}) begin
                    n_err++;
                    $display("FAIL gap0_bit c=%0d: got %b expected %b", c,
                             {b0.so_valid, b0.so, b0.so_last, b0.so_src, b0.req_ready, b0.busy}, {1'b1, e.b, e.last, e.src, 2'b00, 1'b1});
                end
            end
            if (c == 3 * PERIOD0 - 1) b0.req_valid = 2'b00;
            @(negedge clk); #1;
        end
        n_vec++;
        if ({b0.busy, b0.so_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL gap0_end: got %b expected 00", {b0.busy, b0.so_valid});
        end
    endtask

    initial begin
        b.req_valid  = 2'b00;
        b.req_data   = {2*W{1'b0}};
        b0.req_valid = 2'b00;
        b0.req_data  = {2*W{1'b0}};
        test_reset();
        test_basic();
        test_alternate();
        test_reset_mid();
        test_gap0();
        test_data_change();
        test_parity_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
